// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin frame scheduler sharing one UART byte transmitter
// Frames are HDR, requester ID, payload bytes, XOR checksum of ID and payload.
module uart_tx_sched #(
    parameter int          NREQ    = 4,
    parameter int          TIMEOUT = 1024,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [8*NREQ-1:0]   req_data_i,
    input  logic [NREQ-1:0]     req_last_i,
    output logic [NREQ-1:0]     req_ready_o,
    output logic [NREQ-1:0]     grant_o,
    output logic [7:0]          txd_data_o,
    output logic                txd_en_o,
    input  logic                txd_flag_i,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic                timeout_o
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_FETCH} state_t;
    typedef enum logic [1:0] {P_HDR, P_ID, P_PLD, P_CSUM} phase_t;

    state_t         state, state_n;
    phase_t         phase, phase_n;
    logic [GW-1:0]  g, g_n;
    logic [GW-1:0]  last_grant, last_grant_n;
    logic [7:0]     data, data_n;
    logic [7:0]     csum, csum_n;
    logic           last, last_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           done, done_n;

    logic [NREQ-1:0] rot;
    logic [GW:0]     sum;
    logic [GW-1:0]   pick;
    logic            pick_ok;
    logic [7:0]      id_byte;
    logic [7:0]      pld;

    assign id_byte = {{(8-GW){1'b0}}, g};
    assign pld     = req_data_i[{g, 3'b000} +: 8];

    // Rotate requests so bit j is requester last_grant+1+j; lowest set bit wins.
    always_comb begin
        rot     = NREQ'({req_valid_i, req_valid_i} >> ({1'b0, last_grant} + (GW+1)'(1)));
        sum     = '0;
        pick_ok = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sum     = {1'b0, last_grant} + (GW+1)'(j + 1);
                pick_ok = 1'b1;
            end
        end
        pick = (sum >= (GW+1)'(NREQ)) ? GW'(sum - (GW+1)'(NREQ)) : GW'(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase      <= P_HDR;
            g          <= '0;
            last_grant <= GW'(NREQ - 1);
            data       <= '0;
            csum       <= '0;
            last       <= 1'b0;
            cnt        <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            g          <= g_n;
            last_grant <= last_grant_n;
            data       <= data_n;
            csum       <= csum_n;
            last       <= last_n;
            cnt        <= cnt_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n      = state;
        phase_n      = phase;
        g_n          = g;
        last_grant_n = last_grant;
        data_n       = data;
        csum_n       = csum;
        last_n       = last;
        cnt_n        = cnt;
        done_n       = 1'b0;
        timeout_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_ok) begin
                    g_n     = pick;
                    data_n  = HDR;
                    csum_n  = '0;
                    phase_n = P_HDR;
                    state_n = S_SEND;
                end
            end
            S_SEND: state_n = S_WAIT;
            S_WAIT: begin
                if (txd_flag_i) begin
                    case (phase)
                        P_HDR: begin
                            data_n  = id_byte;
                            csum_n  = csum ^ id_byte;
                            phase_n = P_ID;
                            state_n = S_SEND;
                        end
                        P_ID: begin
                            cnt_n   = '0;
                            state_n = S_FETCH;
                        end
                        P_PLD: begin
                            if (last) begin
                                data_n  = csum;
                                phase_n = P_CSUM;
                                state_n = S_SEND;
                            end else begin
                                cnt_n   = '0;
                                state_n = S_FETCH;
                            end
                        end
                        default: begin
                            done_n       = 1'b1;
                            last_grant_n = g;
                            state_n      = S_IDLE;
                        end
                    endcase
                end
            end
            S_FETCH: begin
                if (req_valid_i[g]) begin
                    data_n  = pld;
                    csum_n  = csum ^ pld;
                    last_n  = req_last_i[g];
                    phase_n = P_PLD;
                    cnt_n   = '0;
                    state_n = S_SEND;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    // Stalled requester: close the frame with what has been summed so far.
                    data_n    = csum;
                    phase_n   = P_CSUM;
                    timeout_o = 1'b1;
                    cnt_n     = '0;
                    state_n   = S_SEND;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign txd_en_o     = (state == S_SEND);
    assign busy_o       = (state != S_IDLE);
    assign grant_o      = busy_o ? (NREQ'(1) << g) : '0;
    assign req_ready_o  = (state == S_FETCH) ? (NREQ'(1) << g) : '0;
    assign txd_data_o   = data;
    assign frame_done_o = done;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
// Transaction-level model: requester queues, transmitter with latency, expected frames.
module tb_uart_tx_sched;

    localparam int         NREQ    = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] HDR     = 8'hA5;
    localparam int T_HDR = 0, T_ID = 1, T_PLD = 2, T_PLDL = 3, T_CSUM = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        txd_data;
    logic              txd_en;
    logic              txd_flag;
    logic              busy;
    logic              frame_done;
    logic              timeout;

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .HDR(HDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .grant_o(grant),
        .txd_data_o(txd_data), .txd_en_o(txd_en), .txd_flag_i(txd_flag),
        .busy_o(busy), .frame_done_o(frame_done), .timeout_o(timeout)
    );

    typedef struct {logic [7:0] d; logic l; int dly;} item_t;

    item_t      rq[NREQ][$];
    int         dcnt[NREQ];
    int         total = 0, bad = 0;
    bit         in_frame, f_to, outst, just, rand_lat, spur_en, fetch_mode;
    int         cur_g, m_last, tx_cnt, tx_tag, fix_lat, stall;
    int         n_en = 0, n_done = 0, n_to = 0, n_b2b = 0;
    logic [7:0] tx_byte;
    logic [7:0] f_bytes[$], f_pld[$], done_bytes[$], ex[$];
    int         grant_order[$];
    bit         p_grant, p_acc, p_to, p_flag;
    int         p_g, p_kind;
    item_t      p_item;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int rr();
        int c;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic l, input int dly);
        item_t it;
        it.d = d; it.l = l; it.dly = dly;
        rq[r].push_back(it);
    endtask

    task automatic model_clear();
        in_frame = 0; f_to = 0; outst = 0; just = 0; fetch_mode = 0; stall = 0;
        m_last = NREQ - 1; cur_g = 0;
        p_grant = 0; p_acc = 0; p_to = 0; p_flag = 0;
        f_bytes.delete(); f_pld.delete(); grant_order.delete();
        for (int i = 0; i < NREQ; i++) begin rq[i].delete(); dcnt[i] = 0; end
        req_valid = '0; req_data = '0; req_last = '0; txd_flag = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic frame_check();
        logic [7:0] cs;
        cs = 8'(cur_g);
        ex.delete();
        ex.push_back(HDR);
        ex.push_back(8'(cur_g));
        foreach (f_pld[i]) begin ex.push_back(f_pld[i]); cs = cs ^ f_pld[i]; end
        ex.push_back(cs);
        chk("frame_len", f_bytes.size(), ex.size());
        foreach (ex[i]) if (i < f_bytes.size()) chk("frame_byte", f_bytes[i], ex[i]);
        done_bytes = f_bytes;
    endtask

    task automatic cmp_done(input string tag);
        chk({tag, "_len"}, done_bytes.size(), ex.size());
        foreach (ex[i]) if (i < done_bytes.size()) chk(tag, done_bytes[i], ex[i]);
    endtask

    // One clock: settle expectations of the last edge, check, drive the next edge.
    task automatic cycle();
        int  tag;
        bit  exp_done;
        @(negedge clk);
        tag = -1;
        exp_done = 0;
        if (p_grant) begin
            in_frame = 1; cur_g = p_g; f_to = 0;
            f_bytes.delete(); f_pld.delete();
            grant_order.push_back(p_g);
            tag = T_HDR;
        end
        if (p_acc) begin
            void'(rq[cur_g].pop_front());
            dcnt[cur_g] = 0;
            req_valid[cur_g] = 1'b0;
            f_pld.push_back(p_item.d);
            fetch_mode = 0;
            tag = p_item.l ? T_PLDL : T_PLD;
        end
        if (p_to) begin
            fetch_mode = 0; f_to = 1; n_to++;
            tag = T_CSUM;
        end
        if (p_flag) begin
            case (p_kind)
                T_HDR:        tag = T_ID;
                T_PLDL:       tag = T_CSUM;
                T_ID, T_PLD:  begin fetch_mode = 1; stall = 0; end
                T_CSUM: begin
                    frame_check();
                    exp_done = 1; in_frame = 0; m_last = cur_g; n_done++;
                end
                default: ;
            endcase
        end
        chk("txd_en", txd_en, tag >= 0);
        chk("frame_done", frame_done, exp_done);
        chk("grant", grant, in_frame ? oh(cur_g) : '0);
        chk("busy", busy, in_frame);
        if (txd_en) begin
            n_en++;
            chk("en_before_flag", outst, 0);
            if (tag == T_HDR) chk("hdr_byte", txd_data, HDR);
            f_bytes.push_back(txd_data);
            outst = 1; just = 1; tx_byte = txd_data; tx_tag = tag;
            tx_cnt = rand_lat ? int'($urandom_range(1, 6)) : fix_lat;
        end else if (outst) begin
            chk("data_stable", txd_data, tx_byte);
        end
        p_grant = 0; p_acc = 0; p_to = 0; p_flag = 0;

        if (outst && !just) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                txd_flag = 1'b1; outst = 0; p_flag = 1; p_kind = tx_tag;
            end else begin
                txd_flag = 1'b0;
            end
        end else begin
            txd_flag = spur_en && ($urandom_range(0, 3) == 0);
        end
        just = 0;

        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0 && !req_valid[i]) begin
                if (dcnt[i] >= rq[i][0].dly) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = rq[i][0].d;
                    req_last[i] = rq[i][0].l;
                end else begin
                    dcnt[i]++;
                end
            end
        end

        #1;
        if (fetch_mode) begin
            if (req_valid[cur_g]) begin p_acc = 1; p_item = rq[cur_g][0]; end
            else stall++;
        end
        chk("ready", req_ready, fetch_mode ? oh(cur_g) : '0);
        chk("timeout", timeout, fetch_mode && !req_valid[cur_g] && stall == TIMEOUT);
        if (fetch_mode && !req_valid[cur_g] && stall == TIMEOUT) p_to = 1;
        if (!in_frame && req_valid != '0) begin
            p_grant = 1; p_g = rr();
            if (exp_done) n_b2b++;
        end
    endtask

    task automatic run_idle(input int budget);
        int  n;
        bit  idle;
        n = 0;
        idle = 0;
        while (n < budget && !idle) begin
            cycle();
            n++;
            idle = !in_frame && !p_grant && !outst && req_valid == '0;
            for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) idle = 0;
        end
        chk("run_bound", n < budget, 1);
    endtask

    initial begin
        int d0, e0, t0, n;
        fix_lat = 3; rand_lat = 0; spur_en = 0;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_en", txd_en, 0);
        chk("rst_data", txd_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        // single frame, slow transmitter
        fix_lat = 20;
        d0 = n_done; e0 = n_en;
        push(1, 8'h11, 1'b0, 0);
        push(1, 8'h22, 1'b1, 0);
        run_idle(600);
        chk("single_en_count", n_en - e0, 5);
        chk("single_frames", n_done - d0, 1);
        ex = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h32};
        cmp_done("single_bytes");

        // round robin from reset, back-to-back frames
        do_reset();
        fix_lat = 3;
        push(0, 8'h5A, 1'b1, 0);
        push(0, 8'h3C, 1'b1, 0);
        push(1, 8'h71, 1'b1, 0);
        push(2, 8'h02, 1'b1, 0);
        push(3, 8'hF0, 1'b1, 0);
        n_b2b = 0;
        run_idle(1000);
        chk("rr_count", grant_order.size(), 5);
        if (grant_order.size() == 5) begin
            chk("rr_0", grant_order[0], 0);
            chk("rr_1", grant_order[1], 1);
            chk("rr_2", grant_order[2], 2);
            chk("rr_3", grant_order[3], 3);
            chk("rr_4", grant_order[4], 0);
        end
        chk("b2b_seen", n_b2b > 0, 1);

        // timeout with spurious flags around
        spur_en = 1;
        t0 = n_to;
        push(3, 8'h40, 1'b0, 0);
        run_idle(600);
        chk("timeout_count", n_to - t0, 1);
        ex = '{8'hA5, 8'h03, 8'h40, 8'h43};
        cmp_done("timeout_bytes");

        // reset while second payload byte of req2 is in flight
        fix_lat = 8;
        push(2, 8'h10, 1'b0, 0);
        push(2, 8'h20, 1'b0, 2);
        push(2, 8'h30, 1'b1, 0);
        n = 0;
        while (n < 400 && !(in_frame && cur_g == 2 && f_pld.size() == 2 && outst)) begin
            cycle();
            n++;
        end
        chk("mid_reached", n < 400, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_en", txd_en, 0);
        chk("abort_data", txd_data, 0);
        chk("abort_grant", grant, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 0);
        chk("abort_done", frame_done, 0);
        chk("abort_timeout", timeout, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(0, 8'h81, 1'b1, 0);
        push(2, 8'h82, 1'b1, 0);
        run_idle(600);
        chk("post_rst_count", grant_order.size(), 2);
        if (grant_order.size() == 2) begin
            chk("post_rst_first", grant_order[0], 0);
            chk("post_rst_second", grant_order[1], 2);
        end

        // randomized traffic, random latency, occasional long stalls
        do_reset();
        rand_lat = 1;
        spur_en = 1;
        d0 = n_done;
        for (int i = 0; i < NREQ; i++) begin
            for (int f = 0; f < 4; f++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++)
                    push(i, 8'($urandom), b == len - 1,
                         ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                                     : int'($urandom_range(0, 3)));
            end
        end
        run_idle(20000);
        chk("random_frames", n_done - d0 >= 16, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
